// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// Imported by the state sequencer and its control-word decoder.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, RTYPEWB, BEQEX, IMMEX, IMMWB, JEX
  } statetype;

  // Opcode class captured in DECODE so later states never look at live op.
  typedef enum logic [3:0] {
    OC_NONE, OC_LW, OC_SW, OC_RTYPE, OC_BEQ, OC_J,
    OC_ADDI, OC_ANDI, OC_ORI, OC_SLTI, OC_DADDI
  } opclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_DADDI = 6'b011000;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;
  localparam logic [2:0] ALUOP_DADD  = 3'b110;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
  } ctrl_t;

  function automatic opclass_t decode_op(input logic [5:0] op);
    opclass_t c;
    case (op)
      OP_LW:    c = OC_LW;
      OP_SW:    c = OC_SW;
      OP_RTYPE: c = OC_RTYPE;
      OP_BEQ:   c = OC_BEQ;
      OP_J:     c = OC_J;
      OP_ADDI:  c = OC_ADDI;
      OP_ANDI:  c = OC_ANDI;
      OP_ORI:   c = OC_ORI;
      OP_SLTI:  c = OC_SLTI;
      OP_DADDI: c = OC_DADDI;
      default:  c = OC_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational control-word decoder: state plus latched opcode class in,
// raw datapath control word out (reset masking happens in the top).
module mc_outdec
  import mc_ctrl_pkg::*;
(
  input  statetype   state_i,
  input  opclass_t   class_i,
  input  logic       memready_i,
  output ctrl_t      cw_o
);

  always_comb begin
    cw_o = '0;
    case (state_i)
      FETCH: begin
        cw_o.alusrcb = 2'b01;
        cw_o.irwrite = memready_i;
        cw_o.pcwrite = memready_i;
      end
      DECODE:  cw_o.alusrcb = 2'b11;
      MEMADR: begin
        cw_o.alusrca = 1'b1;
        cw_o.alusrcb = 2'b10;
      end
      MEMRD:   cw_o.iord = 1'b1;
      MEMWB: begin
        cw_o.regwrite = 1'b1;
        cw_o.memtoreg = 1'b1;
      end
      MEMWR: begin
        cw_o.iord     = 1'b1;
        cw_o.memwrite = 1'b1;
      end
      RTYPEEX: begin
        cw_o.alusrca = 1'b1;
        cw_o.aluop   = ALUOP_RTYPE;
      end
      RTYPEWB: begin
        cw_o.regwrite = 1'b1;
        cw_o.regdst   = 1'b1;
      end
      BEQEX: begin
        cw_o.alusrca = 1'b1;
        cw_o.aluop   = ALUOP_SUB;
        cw_o.branch  = 1'b1;
        cw_o.pcsrc   = 2'b01;
      end
      IMMEX: begin
        cw_o.alusrca = 1'b1;
        cw_o.alusrcb = 2'b10;
        case (class_i)
          OC_ANDI:  cw_o.aluop = ALUOP_AND;
          OC_ORI:   cw_o.aluop = ALUOP_OR;
          OC_SLTI:  cw_o.aluop = ALUOP_SLT;
          OC_DADDI: cw_o.aluop = ALUOP_DADD;
          default:  cw_o.aluop = ALUOP_ADD;
        endcase
      end
      IMMWB:   cw_o.regwrite = 1'b1;
      JEX: begin
        cw_o.pcsrc   = 2'b10;
        cw_o.pcwrite = 1'b1;
      end
      default: cw_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: state register, next-state logic,
// opcode-class latch and asynchronous masking of all write enables.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       memready,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] pcsrc,
  output logic [2:0] aluop,
  output logic       illegal,
  output logic [3:0] state_o
);
  import mc_ctrl_pkg::*;

  statetype state_q, state_d;
  opclass_t class_q, class_d;
  opclass_t opDec;
  ctrl_t    cw;

  assign opDec = decode_op(op);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      class_q <= OC_NONE;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
    end
  end

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    case (state_q)
      FETCH:   if (memready) state_d = DECODE;
      DECODE: begin
        class_d = opDec;
        case (opDec)
          OC_LW, OC_SW:  state_d = MEMADR;
          OC_RTYPE:      state_d = RTYPEEX;
          OC_BEQ:        state_d = BEQEX;
          OC_J:          state_d = JEX;
          OC_ADDI, OC_ANDI, OC_ORI, OC_SLTI, OC_DADDI: state_d = IMMEX;
          default:       state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (class_q == OC_SW) ? MEMWR : MEMRD;
      MEMRD:   if (memready) state_d = MEMWB;
      MEMWR:   if (memready) state_d = FETCH;
      RTYPEEX: state_d = RTYPEWB;
      IMMEX:   state_d = IMMWB;
      default: state_d = FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state_i    (state_q),
    .class_i    (class_q),
    .memready_i (memready),
    .cw_o       (cw)
  );

  // Enables are gated by reset directly so an async abort never leaks a write.
  assign pcen     = reset & (cw.pcwrite | (cw.branch & zero));
  assign memwrite = reset & cw.memwrite;
  assign irwrite  = reset & cw.irwrite;
  assign regwrite = reset & cw.regwrite;
  assign illegal  = reset & (state_q == DECODE) & (opDec == OC_NONE);

  assign alusrca  = cw.alusrca;
  assign alusrcb  = cw.alusrcb;
  assign iord     = cw.iord;
  assign memtoreg = cw.memtoreg;
  assign regdst   = cw.regdst;
  assign pcsrc    = cw.pcsrc;
  assign aluop    = cw.aluop;
  assign state_o  = state_q;

endmodule
